// File: rtl/audio_adc_rx_if.sv
// Stereo sample stream from the I2S receiver: show-ahead head of the frame FIFO.
// Consumer pops the head in any cycle where sample_valid & sample_ready.
interface audio_adc_rx_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (output sample_left, sample_right, sample_valid, input sample_ready);
  modport slave  (input sample_left, sample_right, sample_valid, output sample_ready);
endinterface

// File: rtl/audio_adc_rx.sv
// I2S ADC receiver: pins -> 2-flop sync -> deserializer -> show-ahead frame FIFO; last R bit to valid = 2 clk.
// Backpressure: sample_ready stalls the FIFO; a frame arriving while full with no pop is dropped (sticky overflow).
module audio_adc_rx_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     wr_rdy,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_wr, do_rd;

  assign rd_vld = (level_q != '0);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a write.
  assign wr_rdy = (level_q != (AW+1)'(DEPTH)) | rd_rdy;
  assign do_wr  = wr_vld & wr_rdy;
  assign do_rd  = rd_vld & rd_rdy;
  assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
  assign level  = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) level_d = level_q + (AW+1)'(1);
    else if (!do_wr && do_rd) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module audio_adc_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          aud_bclk,
  input  logic                          aud_adclrck,
  input  logic                          aud_adcdat,
  audio_adc_rx_if.master                smp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          framing_err,
  input  logic                          err_clr
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } frame_t;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, SKIP} state_e;

  // Pin synchronizers: [2]=bclk, [1]=lrck, [0]=dat
  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  bclk_h_q, bclk_h_d, lrck_prev_q, lrck_prev_d;
  state_e                state_q, state_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic                  chan_q, chan_d, have_left_q, have_left_d, push_q, push_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, left_q, left_d, right_q, right_d, shifted;
  logic                  overflow_q, overflow_d, framing_err_q, framing_err_d;
  logic                  bclk_s, lrck_s, dat_s, rise, lr_edge, ferr_set, wr_rdy;
  frame_t                wr_frame, head;

  assign bclk_s  = sync2_q[2];
  assign lrck_s  = sync2_q[1];
  assign dat_s   = sync2_q[0];
  assign rise    = bclk_s & ~bclk_h_q;
  assign lr_edge = rise & (lrck_s != lrck_prev_q);
  assign shifted = {shreg_q[DATA_WIDTH-2:0], dat_s};

  always_comb begin
    sync1_d       = {aud_bclk, aud_adclrck, aud_adcdat};
    sync2_d       = sync1_q;
    bclk_h_d      = bclk_s;
    lrck_prev_d   = rise ? lrck_s : lrck_prev_q;
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    chan_d        = chan_q;
    have_left_d   = have_left_q;
    shreg_d       = shreg_q;
    left_d        = left_q;
    right_d       = right_q;
    push_d        = 1'b0;
    ferr_set      = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else if (rise) begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: if (lr_edge && !lrck_s) begin
          state_d     = SHIFT;
          bitcnt_d    = '0;
          chan_d      = 1'b0;
          have_left_d = 1'b0;
        end
        SHIFT: if (lr_edge) begin
          // Slot cut short: drop the partial channel and any pending left half.
          ferr_set    = 1'b1;
          have_left_d = 1'b0;
          bitcnt_d    = '0;
          chan_d      = lrck_s;
        end else begin
          shreg_d  = shifted;
          bitcnt_d = bitcnt_q + CW'(1);
          if (bitcnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = SKIP;
            if (chan_q) begin
              right_d     = shifted;
              push_d      = have_left_q;
              have_left_d = 1'b0;
            end else begin
              left_d      = shifted;
              have_left_d = 1'b1;
            end
          end
        end
        SKIP: if (lr_edge) begin
          state_d  = SHIFT;
          bitcnt_d = '0;
          chan_d   = lrck_s;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wr_frame = '{left: left_q, right: right_q};

  always_comb begin
    overflow_d    = err_clr ? 1'b0 : overflow_q;
    framing_err_d = err_clr ? 1'b0 : framing_err_q;
    if (push_q && !wr_rdy) overflow_d = 1'b1;
    if (ferr_set) framing_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      bclk_h_q      <= 1'b0;
      lrck_prev_q   <= 1'b0;
      state_q       <= IDLE;
      bitcnt_q      <= '0;
      chan_q        <= 1'b0;
      have_left_q   <= 1'b0;
      shreg_q       <= '0;
      left_q        <= '0;
      right_q       <= '0;
      push_q        <= 1'b0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      bclk_h_q      <= bclk_h_d;
      lrck_prev_q   <= lrck_prev_d;
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      chan_q        <= chan_d;
      have_left_q   <= have_left_d;
      shreg_q       <= shreg_d;
      left_q        <= left_d;
      right_q       <= right_d;
      push_q        <= push_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
    end
  end

  audio_adc_rx_fifo #(.WIDTH(2 * DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (push_q),
    .wr_dat  (wr_frame),
    .wr_rdy  (wr_rdy),
    .rd_vld  (smp.sample_valid),
    .rd_rdy  (smp.sample_ready),
    .rd_dat  (head),
    .level   (fifo_level)
  );

  assign smp.sample_left  = head.left;
  assign smp.sample_right = head.right;
  assign overflow         = overflow_q;
  assign framing_err      = framing_err_q;
endmodule
